// File: rtl/fb_pkg.sv
// Shared types for the framebuffer port arbiter.
// Holds widths, read-return tags and the arbitration ranks.
package fb_pkg;

    localparam int FB_ADDR_W = 18;
    localparam int FB_DATA_W = 16;

    // Owner of a read in flight through the BRAM pipeline
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_TRK  = 2'd2
    } rd_tag_t;

    // Arbitration winner; lower value means higher priority
    typedef enum logic [2:0] {
        SEL_IDLE  = 3'd0,
        SEL_VGA   = 3'd1,
        SEL_WR_HI = 3'd2,
        SEL_TRK   = 3'd3,
        SEL_WR_LO = 3'd4
    } arb_sel_t;

    function automatic logic is_write(arb_sel_t s);
        return (s == SEL_WR_HI) || (s == SEL_WR_LO);
    endfunction

    function automatic rd_tag_t sel_tag(arb_sel_t s);
        rd_tag_t t;
        t = TAG_NONE;
        if (s == SEL_VGA) t = TAG_VGA;
        if (s == SEL_TRK) t = TAG_TRK;
        return t;
    endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Small circular FIFO buffering camera pixel writes.
// Caller guarantees no push when full without a pop, no pop when empty.
module fb_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Entry storage needs no reset; count gates every read of it
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally; count tracks push/pop balance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one single-port framebuffer BRAM between VGA, camera and tracker.
// VGA reads win outright; camera writes queue in a FIFO; tracker handshakes.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W,
    parameter int RD_LAT   = 2,
    parameter int WF_DEPTH = 4,
    parameter int HI_WATER = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              cam_we,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_full,
    output logic              cam_overflow,
    input  logic              clr_overflow,
    input  logic              trk_req,
    input  logic [ADDR_W-1:0] trk_addr,
    output logic              trk_grant,
    output logic [DATA_W-1:0] trk_rdata,
    output logic              trk_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(WF_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [CNT_W-1:0] wf_count;
    logic             wf_full;
    logic             wf_empty;
    logic             wf_push;
    logic             wf_pop;
    logic             wf_drop;
    logic [ENT_W-1:0] wf_head;
    arb_sel_t         sel;
    rd_tag_t          tag_q [RD_LAT+1];

    fb_write_fifo #(
        .DEPTH (WF_DEPTH),
        .WIDTH (ENT_W)
    ) u_wfifo (
        .clk   (clk),
        .reset (reset),
        .push  (wf_push),
        .pop   (wf_pop),
        .din   ({cam_addr, cam_data}),
        .head  (wf_head),
        .count (wf_count),
        .full  (wf_full),
        .empty (wf_empty)
    );

    // Fixed-priority pick of the single access issued this cycle
    always_comb begin
        sel = SEL_IDLE;
        if (vga_req)
            sel = SEL_VGA;
        else if (wf_count >= CNT_W'(HI_WATER))
            sel = SEL_WR_HI;
        else if (trk_req)
            sel = SEL_TRK;
        else if (!wf_empty)
            sel = SEL_WR_LO;
    end

    // A full FIFO still accepts a write when its head drains this cycle
    assign wf_pop    = is_write(sel);
    assign wf_push   = cam_we && (!wf_full || wf_pop);
    assign wf_drop   = cam_we && !wf_push;
    assign cam_full  = wf_full;
    assign trk_grant = (sel == SEL_TRK) && !reset;

    // Register the winning access onto the BRAM port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (sel)
                SEL_VGA: mem_addr <= vga_addr;
                SEL_TRK: mem_addr <= trk_addr;
                SEL_WR_HI, SEL_WR_LO: begin
                    mem_we   <= 1'b1;
                    mem_addr <= wf_head[ENT_W-1 -: ADDR_W];
                    mem_din  <= wf_head[DATA_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Tags ride alongside the BRAM pipeline and steer returning data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= TAG_NONE;
            vga_rvalid <= 1'b0;
            trk_rvalid <= 1'b0;
            vga_rdata  <= '0;
            trk_rdata  <= '0;
        end else begin
            tag_q[0] <= sel_tag(sel);
            for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            vga_rvalid <= (tag_q[RD_LAT] == TAG_VGA);
            trk_rvalid <= (tag_q[RD_LAT] == TAG_TRK);
            if (tag_q[RD_LAT] == TAG_VGA) vga_rdata <= mem_dout;
            if (tag_q[RD_LAT] == TAG_TRK) trk_rdata <= mem_dout;
        end
    end

    // Sticky drop flag; a drop in the clearing cycle keeps it set
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cam_overflow <= 1'b0;
        else if (wf_drop)
            cam_overflow <= 1'b1;
        else if (clr_overflow)
            cam_overflow <= 1'b0;
    end

endmodule
